// File: rtl/ft2232h_frame_packer_if.sv
// ft2232h_frame_packer_if: sample input and frame output bundle of the packer.
// slave = packer side; master = sample source plus frame transmitter side.
interface ft2232h_frame_packer_if #(
  parameter int DATA_WIDTH = 14,
  parameter int SAMPLES    = 40
);
  localparam int FRAME_BITS = DATA_WIDTH * SAMPLES;

  logic [DATA_WIDTH-1:0] sample_in;
  logic                  sample_valid;
  logic                  sample_ready;
  logic [0:FRAME_BITS-1] frame_data;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  overflow;
  logic [15:0]           overflow_cnt;

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready,
    output frame_data,
    output frame_valid,
    input  frame_ready,
    output overflow,
    output overflow_cnt
  );

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready,
    input  frame_data,
    input  frame_valid,
    output frame_ready,
    input  overflow,
    input  overflow_cnt
  );
endinterface

// File: rtl/ft2232h_frame_packer.sv
// ft2232h_frame_packer: packs SAMPLES samples into one frame, ping-pong buffered.
// Ports: clk, rst (async, high), bus (slave): sample in/valid/ready,
// frame data/valid/ready, overflow pulse, overflow_cnt.
// Optional FRAME_PACKER_OVF_CNT_EN: saturating dropped-sample counter.
module ft2232h_frame_packer #(
  parameter int DATA_WIDTH = 14,
  parameter int SAMPLES    = 40
) (
  input logic                   clk,
  input logic                   rst,
  ft2232h_frame_packer_if.slave bus
);
  localparam int FRAME_BITS = DATA_WIDTH * SAMPLES;
  localparam int IDX_W = $clog2(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  logic [0:FRAME_BITS-1] buf_q [2];
  logic [1:0]            full_q;
  logic [1:0]            full_d;
  logic                  wr_buf_q;
  logic                  rd_buf_q;
  logic [IDX_W-1:0]      wr_idx_q;
  logic                  ovf_q;

  logic sample_ready;
  logic frame_valid;
  logic accept;
  logic drop;
  logic complete;
  logic consume;

  assign sample_ready = ~full_q[wr_buf_q];
  assign frame_valid  = full_q[rd_buf_q];

  assign accept   = bus.sample_valid & sample_ready;
  assign drop     = bus.sample_valid & ~sample_ready;
  assign complete = accept & (wr_idx_q == LAST_IDX);
  assign consume  = frame_valid & bus.frame_ready;

  assign bus.sample_ready = sample_ready;
  assign bus.frame_valid  = frame_valid;
  assign bus.frame_data   = buf_q[rd_buf_q];
  assign bus.overflow     = ovf_q;

  // Consume and completion always hit different buffers, so both apply.
  always_comb begin
    full_d = full_q;
    if (consume)
      full_d[rd_buf_q] = 1'b0;
    if (complete)
      full_d[wr_buf_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_buf_q <= 1'b0;
      rd_buf_q <= 1'b0;
      wr_idx_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      full_q <= full_d;
      ovf_q  <= drop;
      if (consume)
        rd_buf_q <= ~rd_buf_q;
      if (complete) begin
        wr_buf_q <= ~wr_buf_q;
        wr_idx_q <= '0;
      end else if (accept) begin
        wr_idx_q <= wr_idx_q + 1'b1;
      end
    end
  end

  // Ascending frame range: the slot base index receives the sample MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (accept) begin
      buf_q[wr_buf_q][int'(wr_idx_q)*DATA_WIDTH +: DATA_WIDTH]
        <= bus.sample_in;
    end
  end

`ifdef FRAME_PACKER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_cnt_q <= 16'h0000;
    else if (drop && ovf_cnt_q != 16'hFFFF)
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  assign bus.overflow_cnt = ovf_cnt_q;
`else
  assign bus.overflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ft2232h_frame_packer.sv
// tb_ft2232h_frame_packer: directed vector table plus corner sequences
// for the ping-pong frame packer.
module tb_ft2232h_frame_packer;
  localparam int DW = 14;
  localparam int NS = 40;
  localparam int LAST = DW * (NS - 1);

`ifdef FRAME_PACKER_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          fr;
    logic          e_sr;
    logic          e_fv;
    logic          e_ov;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];

  ft2232h_frame_packer_if #(.DATA_WIDTH(DW), .SAMPLES(NS)) bus ();

  ft2232h_frame_packer #(.DATA_WIDTH(DW), .SAMPLES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [DW-1:0] d,
                      input logic fr);
    @(negedge clk);
    bus.sample_valid = v;
    bus.sample_in    = d;
    bus.frame_ready  = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.frame_ready  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input logic v, input logic [DW-1:0] d, input logic fr,
                     input logic sr, input logic fv, input logic ov);
    vec_t e;
    e.v = v; e.d = d; e.fr = fr;
    e.e_sr = sr; e.e_fv = fv; e.e_ov = ov;
    tbl.push_back(e);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].fr);
      chk($sformatf("vec%0d sr/fv/ov", i),
          {29'd0, bus.sample_ready, bus.frame_valid, bus.overflow},
          {29'd0, tbl[i].e_sr, tbl[i].e_fv, tbl[i].e_ov});
    end
  endtask

  task automatic chk_frame(input string name, input logic [DW-1:0] first,
                           input logic [DW-1:0] last);
    chk({name, "_first"}, 32'(bus.frame_data[0 +: DW]), 32'(first));
    chk({name, "_last"}, 32'(bus.frame_data[LAST +: DW]), 32'(last));
  endtask

  initial begin
    int nfr;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.frame_ready  = 1'b0;

    // Samples 1..40 fill buffer 0, 41..80 buffer 1, 81st is dropped,
    // then a lone consume frees buffer 0.
    for (int i = 0; i < 39; i++)
      add(1'b1, DW'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, DW'(40), 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 40; i < 79; i++)
      add(1'b1, DW'(i + 1), 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, DW'(80), 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, DW'(14'h3FFF), 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, DW'(0), 1'b1, 1'b1, 1'b1, 1'b0);

    #12;
    chk("rst_sready", 32'(bus.sample_ready), 32'd1);
    chk("rst_fvalid", 32'(bus.frame_valid), 32'd0);
    chk("rst_fdata", 32'(|bus.frame_data), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_cnt", 32'(bus.overflow_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_vecs(0, 39);
    chk_frame("f1", 14'h0001, 14'h0028);
    run_vecs(40, 80);
    chk("cnt_one", 32'(bus.overflow_cnt), CNT_EN ? 32'd1 : 32'd0);
    chk_frame("f1_hold", 14'h0001, 14'h0028);
    run_vecs(81, 81);
    chk_frame("f2", 14'h0029, 14'h0050);

    // Completion of frame 3 on the same edge that consumes frame 2.
    for (int i = 0; i < 39; i++)
      tick(1'b1, DW'(14'h100 + i), 1'b0);
    tick(1'b1, DW'(14'h127), 1'b1);
    chk("sim_fvalid", 32'(bus.frame_valid), 32'd1);
    chk("sim_ovf", 32'(bus.overflow), 32'd0);
    chk("sim_sready", 32'(bus.sample_ready), 32'd1);
    chk_frame("f3", 14'h0100, 14'h0127);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 17; i++)
      tick(1'b1, DW'(14'h180 + i), 1'b0);
    #2;
    bus.sample_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_fvalid", 32'(bus.frame_valid), 32'd0);
    chk("arst_sready", 32'(bus.sample_ready), 32'd1);
    chk("arst_fdata", 32'(|bus.frame_data), 32'd0);
    chk("arst_ovf", 32'(bus.overflow), 32'd0);
    chk("arst_cnt", 32'(bus.overflow_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++)
      tick(1'b1, DW'(14'h200 + i), 1'b0);
    chk("clean_fvalid", 32'(bus.frame_valid), 32'd1);
    chk_frame("clean", 14'h0200, 14'h0227);

    // Overflow counter saturation.
    do_reset();
    for (int i = 0; i < 80; i++)
      tick(1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 70000; i++) begin
      tick(1'b1, DW'(i), 1'b0);
      if (i == 65533)
        chk("cnt_fffe", 32'(bus.overflow_cnt),
            CNT_EN ? 32'hFFFE : 32'd0);
    end
    chk("cnt_sat", 32'(bus.overflow_cnt), CNT_EN ? 32'hFFFF : 32'd0);
    chk("sat_ovf", 32'(bus.overflow), 32'd1);
    chk("sat_sready", 32'(bus.sample_ready), 32'd0);

    // Streaming with the transmitter always ready.
    do_reset();
    nfr = 0;
    for (int c = 0; c < 402; c++) begin
      @(negedge clk);
      if (bus.frame_valid) begin
        if (nfr < 10)
          chk_frame($sformatf("strm%0d", nfr),
                    DW'(nfr * 40 + 1), DW'(nfr * 40 + 40));
        nfr++;
      end
      bus.sample_valid = (c < 400);
      bus.sample_in    = DW'(c + 1);
      bus.frame_ready  = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("strm_ovf%0d", c), 32'(bus.overflow), 32'd0);
    end
    chk("strm_frames", 32'(nfr), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
